// File: rtl/svc_rv_imem_sram.sv
// Zero-latency instruction SRAM for the fetch port, filled by a byte-stream loader FSM.
// Optional feature macro SVC_RV_IMEM_LOAD_CKSUM_EN adds ld_cksum (mod-256 sum of loaded bytes).
module svc_rv_imem_sram #(
    parameter int          DEPTH    = 1024,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imem_ren,
    input  logic [31:0]   imem_raddr,
    output logic [31:0]   imem_rdata,
    input  logic          ld_start,
    input  logic [31:0]   ld_base,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [7:0]    ld_data,
    input  logic          ld_end,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          ld_overflow,
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
    output logic [7:0]    ld_cksum,
`endif
    output logic [AW:0]   ld_words
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [31:0] mem_r [DEPTH];
    state_t      state_r;
    logic [AW:0] waddr_r;
    logic [1:0]  bcnt_r;
    logic [31:0] word_r;

    logic        restart_s;
    logic        byte_acc_s;
    logic        in_range_s;
    logic        commit_s;
    logic [31:0] commit_data_s;
    logic [31:0] assembled_s;
    logic        out_of_range_s;
    logic        unused_s;

    assign unused_s = ^{imem_ren, ld_base[31:AW+2], ld_base[1:0]};

    // Combinational fetch read; a same-cycle write lands at the clock edge, so reads see old data.
    always_comb begin
        out_of_range_s = (imem_raddr[31:AW+2] != {(30-AW){1'b0}});
        if (out_of_range_s) begin
            imem_rdata = NOP_WORD;
        end else begin
            imem_rdata = mem_r[imem_raddr[AW+1:2]];
        end
    end

    // Byte-lane assembly and word-commit decode.
    always_comb begin
        restart_s   = ld_start && (state_r != DONE);
        byte_acc_s  = ld_ready && ld_valid && !ld_start;
        in_range_s  = !waddr_r[AW];
        assembled_s = word_r;
        assembled_s[{bcnt_r, 3'b000} +: 8] = ld_data;
        if (byte_acc_s && (bcnt_r == 2'd3)) begin
            commit_s      = 1'b1;
            commit_data_s = assembled_s;
        end else if ((state_r == FLUSH) && !ld_start && (bcnt_r != 2'd0)) begin
            commit_s      = 1'b1;
            commit_data_s = word_r;
        end else begin
            commit_s      = 1'b0;
            commit_data_s = word_r;
        end
    end

    // Array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit_s && in_range_s && !rst) begin
            mem_r[waddr_r[AW-1:0]] <= commit_data_s;
        end
    end

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            waddr_r     <= {(AW+1){1'b0}};
            bcnt_r      <= 2'd0;
            word_r      <= 32'h0000_0000;
            ld_ready    <= 1'b0;
            ld_busy     <= 1'b0;
            ld_done     <= 1'b0;
            ld_overflow <= 1'b0;
            ld_words    <= {(AW+1){1'b0}};
        end else if (restart_s) begin
            state_r     <= LOAD;
            waddr_r     <= {1'b0, ld_base[AW+1:2]};
            bcnt_r      <= 2'd0;
            word_r      <= 32'h0000_0000;
            ld_ready    <= 1'b1;
            ld_busy     <= 1'b1;
            ld_done     <= 1'b0;
            ld_overflow <= 1'b0;
            ld_words    <= {(AW+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_done  <= 1'b0;
                end
                LOAD: begin
                    if (byte_acc_s) begin
                        if (bcnt_r == 2'd3) begin
                            word_r <= 32'h0000_0000;
                            bcnt_r <= 2'd0;
                        end else begin
                            word_r <= assembled_s;
                            bcnt_r <= bcnt_r + 2'd1;
                        end
                    end
                    // The byte of this cycle (if any) is absorbed above before flushing.
                    if (ld_end) begin
                        state_r  <= FLUSH;
                        ld_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    bcnt_r  <= 2'd0;
                    word_r  <= 32'h0000_0000;
                    state_r <= DONE;
                    ld_busy <= 1'b0;
                    ld_done <= 1'b1;
                end
                DONE: begin
                    state_r  <= IDLE;
                    ld_done  <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_ready <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
            // Writes past the array are dropped and the address saturates at DEPTH.
            if (commit_s) begin
                if (in_range_s) begin
                    waddr_r  <= waddr_r + {{AW{1'b0}}, 1'b1};
                    ld_words <= ld_words + {{AW{1'b0}}, 1'b1};
                end else begin
                    ld_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
    logic [7:0] cksum_r;

    // Running byte sum; untouched after DONE until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_r <= 8'h00;
        end else if (restart_s) begin
            cksum_r <= 8'h00;
        end else if (byte_acc_s) begin
            cksum_r <= cksum_r + ld_data;
        end else begin
            cksum_r <= cksum_r;
        end
    end

    assign ld_cksum = cksum_r;
`endif

endmodule

// File: tb/tb_svc_rv_imem_sram.sv
// Scoreboard bench for svc_rv_imem_sram: randomized loads and reads checked against a word-array model.
module tb_svc_rv_imem_sram;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        ld_start;
    logic [31:0] ld_base;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_end;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_overflow;
    logic [AW:0] ld_words;
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
    logic [7:0]  ld_cksum;
`endif

    always #5 clk = ~clk;

    svc_rv_imem_sram #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_end(ld_end), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_overflow(ld_overflow),
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
        .ld_cksum(ld_cksum),
`endif
        .ld_words(ld_words)
    );

    typedef struct {
        int         words;
        bit         ovf;
        logic [7:0] ck;
    } done_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mm [DEPTH];
    bit          mv [DEPTH];
    logic [31:0] rd_q[$];
    done_t       done_q[$];
    logic [7:0]  ld_q[$];
    int          known_q[$];
    logic [31:0] mon_e;
    done_t       mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:AW+2] != 0) return NOP;
        return mm[a[AW+1:2]];
    endfunction

    task automatic push_read(input logic [31:0] a, input logic [31:0] e);
        imem_raddr = a;
        imem_ren   = 1'b1;
        rd_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        imem_ren = 1'b0;
    endtask

    // Monitor: pops expected read data and load results whenever the DUT presents them.
    always @(negedge clk) begin
        if (imem_ren) begin
            if (rd_q.size() == 0) begin
                chk("read_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = rd_q.pop_front();
                chk("imem_rdata", imem_rdata, mon_e);
            end
        end
        if (ld_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                mon_d = done_q.pop_front();
                chk("ld_words", 32'(ld_words), mon_d.words);
                chk("ld_overflow", 32'(ld_overflow), 32'(mon_d.ovf));
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
                chk("ld_cksum", 32'(ld_cksum), 32'(mon_d.ck));
`endif
            end
        end
    end

    // Full load of ld_q at base; optional same-cycle read probe at byte index probe_at.
    task automatic do_load(input logic [31:0] base, input bit end_last,
                           input int probe_at, input logic [31:0] probe_addr);
        int          n  = ld_q.size();
        int          bw = int'((base >> 2) % DEPTH);
        int          nw = (n + 3) / 4;
        done_t       d;
        int          ua[$];
        logic [31:0] ud[$];
        logic [31:0] w;
        logic [31:0] nv;
        d.words = 0;
        d.ovf   = 1'b0;
        d.ck    = 8'h00;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * i + j < n) w[8*j +: 8] = ld_q[4*i+j];
            end
            if (bw + i < DEPTH) begin
                ua.push_back(bw + i);
                ud.push_back(w);
                d.words++;
            end else begin
                d.ovf = 1'b1;
            end
        end
        foreach (ld_q[i]) d.ck = d.ck + ld_q[i];

        ld_base  = base;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("start_busy", 32'(ld_busy), 32'd1);
        chk("start_ready", 32'(ld_ready), 32'd1);
        chk("start_words", 32'(ld_words), 32'd0);
        chk("start_ovf", 32'(ld_overflow), 32'd0);
        done_q.push_back(d);

        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            ld_valid = 1'b1;
            ld_data  = ld_q[i];
            ld_end   = end_last && (i == n - 1);
            chk("hs_ready", 32'(ld_ready), 32'd1);
            if (i == probe_at) push_read(probe_addr, model_read(probe_addr));
            step();
            ld_valid = 1'b0;
            ld_end   = 1'b0;
            ld_data  = 8'($urandom);
            if (i == probe_at) begin
                nv = model_read(probe_addr);
                foreach (ua[k]) if (ua[k] == int'(probe_addr[AW+1:2])) nv = ud[k];
                push_read(probe_addr, nv);
            end
        end
        if (!end_last) begin
            ld_end = 1'b1;
            step();
            ld_end = 1'b0;
        end
        chk("flush_busy", 32'(ld_busy), 32'd1);
        chk("flush_ready", 32'(ld_ready), 32'd0);
        chk("flush_done", 32'(ld_done), 32'd0);
        step();
        chk("done_pulse", 32'(ld_done), 32'd1);
        chk("done_busy", 32'(ld_busy), 32'd0);
        step();
        chk("done_once", 32'(ld_done), 32'd0);
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
        chk("cksum_held", 32'(ld_cksum), 32'(d.ck));
`endif
        foreach (ua[k]) begin
            mm[ua[k]] = ud[k];
            if (!mv[ua[k]]) known_q.push_back(ua[k]);
            mv[ua[k]] = 1'b1;
        end
        ld_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          n;
        rst = 1'b1; imem_ren = 1'b0; imem_raddr = 32'h0; ld_start = 1'b0;
        ld_base = 32'h0; ld_valid = 1'b0; ld_data = 8'h00; ld_end = 1'b0;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        imem_raddr = 32'h0;
        chk("reset_no_x", 32'($isunknown({ld_ready, ld_busy, ld_done, ld_overflow, ld_words})), 32'd0);
        chk("reset_ready", 32'(ld_ready), 32'd0);
        chk("reset_busy", 32'(ld_busy), 32'd0);
        chk("reset_ovf", 32'(ld_overflow), 32'd0);
        chk("reset_words", 32'(ld_words), 32'd0);

        // Valid outside LOAD is ignored.
        ld_valid = 1'b1; ld_data = 8'h77;
        repeat (3) begin
            step();
            chk("idle_ready", 32'(ld_ready), 32'd0);
        end
        ld_valid = 1'b0;

        ld_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h05, 8'h00, 8'h10};
        do_load(32'h10, 1'b0, -1, 32'h0);
        chk("model_w4", mm[4], 32'h00000013);
        chk("model_w5", mm[5], 32'h10000537);
        foreach (known_q[i]) ;
        push_read(32'h10, 32'h00000013); step();
        push_read(32'h14, 32'h10000537); step();
        push_read(32'h11, 32'h00000013); step();
        push_read(32'h13, 32'h00000013); step();

        ld_q = '{8'hAA, 8'hBB, 8'hCC};
        do_load(32'h100, 1'b0, -1, 32'h0);
        push_read(32'h100, 32'h00CCBBAA); step();
        ld_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        do_load(32'h200, 1'b1, -1, 32'h0);
        push_read(32'h204, model_read(32'h204)); step();

        // Same-cycle read of word 1 while it commits.
        for (int i = 0; i < 8; i++) ld_q.push_back(8'($urandom));
        do_load(32'h0, 1'b0, -1, 32'h0);
        for (int i = 0; i < 8; i++) ld_q.push_back(8'($urandom));
        do_load(32'h0, 1'b0, 7, 32'h4);
        push_read(32'h4000, NOP); step();

        // Overflow at the top of the array; word 0 must survive.
        for (int i = 0; i < 16; i++) ld_q.push_back(8'(i + 1));
        do_load(32'hFF8, 1'b0, -1, 32'h0);
        push_read(32'h0, model_read(32'h0)); step();
        push_read(32'hFF8, 32'h04030201); step();
        push_read(32'hFFC, 32'h08070605); step();

        ld_q = '{8'h01, 8'h02, 8'h03, 8'hFF};
        do_load(32'h40, 1'b0, -1, 32'h0);

        // Reset mid-load discards the partial word.
        ld_base = 32'h40; ld_start = 1'b1; step(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hDE; step();
        ld_data = 8'hAD; step();
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(ld_busy), 32'd0);
        chk("rst_words", 32'(ld_words), 32'd0);
`ifdef SVC_RV_IMEM_LOAD_CKSUM_EN
        chk("rst_cksum", 32'(ld_cksum), 32'd0);
`endif
        step();
        rst = 1'b0;
        push_read(32'h40, 32'h FF030201); step();
        ld_q = '{8'h9C};
        do_load(32'h44, 1'b1, -1, 32'h0);

        // Restart from LOAD drops three pending bytes.
        ld_base = 32'h80; ld_start = 1'b1; step(); ld_start = 1'b0;
        ld_valid = 1'b1;
        repeat (3) begin ld_data = 8'($urandom); step(); end
        ld_valid = 1'b0;
        ld_q = '{8'h5E};
        do_load(32'h300, 1'b0, -1, 32'h0);
        push_read(32'h300, 32'h0000005E); step();

        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
            a = (k % 2 == 1) ? 32'($urandom_range(DEPTH * 4 - 40, DEPTH * 4 - 1))
                             : 32'($urandom_range(0, DEPTH * 4 - 1));
            do_load(a, 1'($urandom_range(0, 1)), -1, 32'h0);
        end
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                if (a[31:AW+2] == 0) a[31] = 1'b1;
            end else begin
                a = {20'h0, 10'(known_q[$urandom_range(0, known_q.size() - 1)]), 2'($urandom)};
            end
            push_read(a, model_read(a));
            step();
        end
        step();
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
